// File: rtl/loop_ctl_if.sv
// loop_ctl_if: bundles the loop request, the counter control lines and the
// status outputs of loop_ctl into one interface.
// Optional feature macro: LOOP_LAST_EN (adds the 'last' signal).
//
// Handshake: 'start' is a request that is sampled only while the sequencer is
// idle (busy = 0, done = 0); 'count' must be valid in the same cycle. There is
// no ready signal. A request outside idle is dropped. Completion is signalled
// by a single-cycle 'done'. An aborted loop ends without 'done'.
interface loop_ctl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] count;
    logic             abort;
    logic             cout;
    logic             clout;
    logic [1:0]       mode;
    logic [WIDTH-1:0] preset;
    logic             busy;
    logic             step;
    logic             done;
`ifdef LOOP_LAST_EN
    logic             last;

    // Upstream side: microsequencer plus the attached counter's flags.
    modport master (
        output start, count, abort, cout, clout,
        input  mode, preset, busy, step, done, last
    );

    // Sequencer side.
    modport slave (
        input  start, count, abort, cout, clout,
        output mode, preset, busy, step, done, last
    );
`else
    // Upstream side: microsequencer plus the attached counter's flags.
    modport master (
        output start, count, abort, cout, clout,
        input  mode, preset, busy, step, done
    );

    // Sequencer side.
    modport slave (
        input  start, count, abort, cout, clout,
        output mode, preset, busy, step, done
    );
`endif
endinterface

// File: rtl/loop_ctl.sv
// loop_ctl: loop sequencer in front of a sync-load up/down counter.
// It loads the counter with the iteration count and commands one decrement
// per clock until the counter reports terminal count, then pulses 'done'.
// Optional feature macro: LOOP_LAST_EN (drives 'last' from the counter's
// one-before-terminal flag 'clout'; without it, 'clout' is ignored).
module loop_ctl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    loop_ctl_if.slave  bus,
    output logic [1:0] o_dbg_state,
    output logic       o_dbg_fresh
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_preset;
    logic             r_fresh;
    logic             w_qcout;
    logic             w_step;
    logic [1:0]       w_mode;

    // The counter's cout is left over from the previous loop until the first
    // decrement of this loop has happened, so it is ignored in the first RUN
    // cycle.
    assign w_qcout = bus.cout & ~r_fresh;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and counter-mode decode; abort takes priority over terminal
    // count so an aborted loop never produces 'done'.
    always_comb begin
        w_next = r_state;
        w_mode = MODE_HOLD;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_mode = MODE_LOAD;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (w_qcout) begin
                    w_next = S_DONE;
                end else begin
                    w_mode = MODE_DEC;
                    w_step = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the iteration count with an accepted request; holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_preset <= bus.count;
        end
    end

    // First-RUN-cycle flag: set on the LOAD -> RUN transition, clear otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fresh <= 1'b0;
        end else begin
            r_fresh <= (r_state == S_LOAD) & ~bus.abort;
        end
    end

    assign bus.mode   = w_mode;
    assign bus.step   = w_step;
    assign bus.preset = r_preset;
    assign bus.busy   = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);

`ifdef LOOP_LAST_EN
    // clout is not meaningful before the first decrement, so in the first
    // step cycle 'last' is true only for a single-iteration loop.
    assign bus.last = w_step & (r_fresh ? (r_preset == WIDTH'(1)) : bus.clout);
`else
    logic w_unused_clout;
    assign w_unused_clout = bus.clout;
`endif

    assign o_dbg_state = r_state;
    assign o_dbg_fresh = r_fresh;

endmodule
